chaser_multi: RTL and testbench
===============================

Name: chaser_multi

Overview:
- Parametrised LED chaser, the successor to the fixed 4-LED one-hot chaser.
- Drives NUM_LEDS outputs from a step prescaler, with three run-time patterns (chase, bounce, fill), direction control, enable/pause and a freeze mode.
- Sits directly behind the on-chip oscillator clock and drives board LEDs or other status outputs.
- Exposes position and a once-per-cycle wrap pulse so other blocks can synchronise to it.

Parameters:
- NUM_LEDS, 4: number of LED outputs; legal range >= 2.
- STEP_CYCLES, 1048576: clock cycles per pattern step; legal range >= 2.
- PW, $clog2(NUM_LEDS): width of pos (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  1 = run prescaler and pattern; 0 = freeze all state.
- mode  in  2  00 CHASE, 01 BOUNCE, 10 FILL, 11 HOLD; sampled only at a tick.
- dir  in  1  0 = up (toward LED NUM_LEDS-1), 1 = down; used in CHASE and FILL only.
- leds  out  NUM_LEDS  registered LED drive.
- pos  out  PW  registered current position, 0..NUM_LEDS-1.
- wrap  out  1  registered one-cycle pulse at the end of each pattern cycle.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: prescaler=0, pos=0, bounce direction bdir=up, mode_q=CHASE, leds=1 (LED0 on), wrap=0. Reset may assert mid-step; all state returns to these values immediately.
- Prescaler:
  - Counts 0..STEP_CYCLES-1 while en=1.
  - Tick = en && cnt==STEP_CYCLES-1.
  - On the tick edge, cnt returns to 0 and a step is taken on that same edge.
  - en=0 holds cnt, pos, bdir, mode_q and leds; wrap=0.
- At each tick, mode_q<=mode and the next pos is computed using the new mode:
  - CHASE, dir=0: pos+1, wrapping N-1->0. dir=1: pos-1, wrapping 0->N-1.
  - BOUNCE (dir ignored):
    - If bdir=up and pos<N-1: pos+1.
    - If bdir=up and pos==N-1: pos-1, bdir<=down.
    - If bdir=down and pos>0: pos-1.
    - If bdir=down and pos==0: pos+1, bdir<=up.
    - Entering BOUNCE keeps the current pos and bdir.
  - FILL: pos advances exactly as in CHASE.
  - HOLD: pos, bdir unchanged; leds unchanged.
- leds encoding (registered on the same edge as pos, so they are always consistent):
  - CHASE/BOUNCE: one-hot, bit pos set.
  - FILL dir=0: bits 0..pos set. FILL dir=1: bits pos..N-1 set.
  - leds change only at ticks or reset; a mode or dir change between ticks has no visible effect until the next tick.
- wrap asserts for exactly one cycle on the tick edge when:
  - CHASE/FILL: pos goes N-1->0 (up) or 0->N-1 (down).
  - BOUNCE: pos turns around at 0 (down->up).
  - wrap is never asserted in HOLD.
- Arithmetic:
  - pos arithmetic is modulo NUM_LEDS; it is correct for non-power-of-two NUM_LEDS (e.g. 5 gives 4->0, not 4->5).
  - The prescaler counter width is $clog2(STEP_CYCLES).
- Combinational decode must not create latches; leds must never show a glitch-free-violating multi-hot value in CHASE/BOUNCE.

Test Plan:
1. NUM_LEDS=4, STEP_CYCLES=4, CHASE dir=0, en=1 after reset -> leds 0001, then 0010 on the 4th rising edge, 0100 at 8, 1000 at 12, 0001 at 16 with wrap=1 for that one cycle only.
2. Same setup, dir=1 -> leds 0001 then 1000 (wrap=1), 0100, 0010, 0001; pos sequence 0,3,2,1,0.
3. BOUNCE, NUM_LEDS=4 -> pos 0,1,2,3,2,1,0,1; wrap=1 only on the step into pos 1 after pos 0 (the 0 turnaround); pos 3 is held for one step only.
4. FILL dir=0, NUM_LEDS=5 -> leds 00001,00011,00111,01111,11111,00001 (wrap=1); pos never reaches 5.
5. en deasserted at cnt=2 for 10 cycles, then reasserted -> the next tick arrives exactly 2 enabled cycles later; leds unchanged while en=0. Switching mode to HOLD mid-step -> leds frozen at the next tick, wrap stays 0.
6. rst_n pulsed low asynchronously mid-step at pos=2 in BOUNCE down -> leds=0001, pos=0, wrap=0 immediately without a clock edge; after release in BOUNCE -> next steps are 1,2 (bdir=up).

Source files
------------

// File: rtl/chaser_multi.sv
// Parametrised LED chaser: prescaled step engine with chase, bounce and fill
// patterns, direction control, enable/pause, hold mode and a cycle-wrap pulse.
module chaser_multi #(
    parameter int NUM_LEDS    = 4,
    parameter int STEP_CYCLES = 1048576,
    parameter int PW          = $clog2(NUM_LEDS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                dir,
    output logic [NUM_LEDS-1:0] leds,
    output logic [PW-1:0]       pos,
    output logic                wrap
);

    localparam int              CW       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [PW-1:0]   POS_LAST = PW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        BDIR_UP   = 1'b0,
        BDIR_DOWN = 1'b1
    } bdir_e;

    logic [CW-1:0]       cnt_q,  cnt_d;
    logic [PW-1:0]       pos_q,  pos_d;
    bdir_e               bdir_q, bdir_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                wrap_q, wrap_d;
    logic                tick_s;
    mode_e               mode_s;

    // LED image for a position: one-hot for chase/bounce, a bar for fill
    function automatic logic [NUM_LEDS-1:0] led_pattern(input mode_e m, input logic d,
                                                        input logic [PW-1:0] p);
        logic [NUM_LEDS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (m)
                MODE_FILL: v[i] = d ? (i >= int'(p)) : (i <= int'(p));
                default:   v[i] = (i == int'(p));
            endcase
        end
        return v;
    endfunction

    function automatic logic [PW-1:0] pos_inc(input logic [PW-1:0] p);
        return (p == POS_LAST) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] pos_dec(input logic [PW-1:0] p);
        return (p == '0) ? POS_LAST : p - PW'(1);
    endfunction

    assign tick_s = en && (cnt_q == CNT_LAST);
    assign mode_s = mode_e'(mode);

    // Prescaler advance and pattern step decode
    always_comb begin
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        bdir_d = bdir_q;
        leds_d = leds_q;
        wrap_d = 1'b0;
        if (tick_s) begin
            cnt_d = '0;
            case (mode_s)
                MODE_CHASE, MODE_FILL: begin
                    if (dir) begin
                        pos_d  = pos_dec(pos_q);
                        wrap_d = (pos_q == '0);
                    end else begin
                        pos_d  = pos_inc(pos_q);
                        wrap_d = (pos_q == POS_LAST);
                    end
                    leds_d = led_pattern(mode_s, dir, pos_d);
                end
                MODE_BOUNCE: begin
                    // Turnaround steps away from the end immediately, so each end is held one step
                    if (bdir_q == BDIR_UP) begin
                        if (pos_q == POS_LAST) begin
                            pos_d  = pos_q - PW'(1);
                            bdir_d = BDIR_DOWN;
                        end else begin
                            pos_d  = pos_q + PW'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d  = PW'(1);
                            bdir_d = BDIR_UP;
                            wrap_d = 1'b1;
                        end else begin
                            pos_d  = pos_q - PW'(1);
                        end
                    end
                    leds_d = led_pattern(mode_s, dir, pos_d);
                end
                MODE_HOLD: begin
                    pos_d  = pos_q;
                end
                default: begin
                    pos_d  = pos_q;
                end
            endcase
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; en=0 simply holds everything because the decode holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pos_q  <= '0;
            bdir_q <= BDIR_UP;
            leds_q <= NUM_LEDS'(1);
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            bdir_q <= bdir_d;
            leds_q <= leds_d;
            wrap_q <= wrap_d;
        end
    end

    assign leds = leds_q;
    assign pos  = pos_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_chaser_multi.sv
// Self-checking bench for chaser_multi: a 4-LED and a 5-LED instance driven by
// shared directed and random stimulus, compared against an integer reference model.
module tb_chaser_multi;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       dir;

    logic [3:0] u4_leds;
    logic [1:0] u4_pos;
    logic       u4_wrap;
    logic [4:0] u5_leds;
    logic [2:0] u5_pos;
    logic       u5_wrap;

    int checks;
    int failures;

    int m_cnt  [2];
    int m_pos  [2];
    int m_bdir [2];
    int m_leds [2];
    int m_wrap [2];

    chaser_multi #(.NUM_LEDS(4), .STEP_CYCLES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir),
        .leds(u4_leds), .pos(u4_pos), .wrap(u4_wrap)
    );

    chaser_multi #(.NUM_LEDS(5), .STEP_CYCLES(3)) u5 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir),
        .leds(u5_leds), .pos(u5_pos), .wrap(u5_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nl(input int k);
        return (k == 0) ? 4 : 5;
    endfunction

    function automatic int sc(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_pos[k]  = 0;
            m_bdir[k] = 0;
            m_leds[k] = 1;
            m_wrap[k] = 0;
        end
    endtask

    // One pattern step using the rules in plain modulo arithmetic
    task automatic model_step(input int k);
        int n;
        n = nl(k);
        if (mode == 2'd0 || mode == 2'd2) begin
            if (dir == 1'b0) begin
                m_wrap[k] = (m_pos[k] == n - 1) ? 1 : 0;
                m_pos[k]  = (m_pos[k] + 1) % n;
            end else begin
                m_wrap[k] = (m_pos[k] == 0) ? 1 : 0;
                m_pos[k]  = (m_pos[k] + n - 1) % n;
            end
            if (mode == 2'd0)
                m_leds[k] = 1 << m_pos[k];
            else if (dir == 1'b0)
                m_leds[k] = (1 << (m_pos[k] + 1)) - 1;
            else
                m_leds[k] = ((1 << n) - 1) & ~((1 << m_pos[k]) - 1);
        end else if (mode == 2'd1) begin
            if (m_bdir[k] == 0 && m_pos[k] == n - 1) m_bdir[k] = 1;
            else if (m_bdir[k] == 1 && m_pos[k] == 0) begin
                m_bdir[k] = 0;
                m_wrap[k] = 1;
            end
            m_pos[k]  = (m_bdir[k] == 0) ? m_pos[k] + 1 : m_pos[k] - 1;
            m_leds[k] = 1 << m_pos[k];
        end
    endtask

    task automatic model_edge(input int k);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_wrap[k] = 0;
            if (en) begin
                if (m_cnt[k] == sc(k) - 1) begin
                    m_cnt[k] = 0;
                    model_step(k);
                end else begin
                    m_cnt[k]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("u4_leds", 32'(u4_leds), m_leds[0]);
        check("u4_pos",  32'(u4_pos),  m_pos[0]);
        check("u4_wrap", 32'(u4_wrap), m_wrap[0]);
        check("u5_leds", 32'(u5_leds), m_leds[1]);
        check("u5_pos",  32'(u5_pos),  m_pos[1]);
        check("u5_wrap", 32'(u5_wrap), m_wrap[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        @(negedge clk);
        compare_all();
    endtask

    // Reset asserted between edges must clear outputs with no clock edge
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("arst_u4_leds", 32'(u4_leds), 32'd1);
        check("arst_u4_pos",  32'(u4_pos),  32'd0);
        check("arst_u4_wrap", 32'(u4_wrap), 32'd0);
        check("arst_u5_leds", 32'(u5_leds), 32'd1);
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        mode     = 2'd0;
        dir      = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_u4_leds", 32'(u4_leds), 32'd1);
        check("rst_u4_pos",  32'(u4_pos),  32'd0);
        check("rst_u4_wrap", 32'(u4_wrap), 32'd0);
        check("rst_u5_leds", 32'(u5_leds), 32'd1);
        rst_n = 1'b1;
        en    = 1'b1;

        // chase up: first step on the 4th edge, wrap on the 16th
        for (int i = 1; i <= 16; i++) begin
            cycle();
            if (i == 3) check("chase_pre_tick", 32'(u4_leds), 32'd1);
            if (i == 4) check("chase_step1", 32'(u4_leds), 32'd2);
        end
        check("chase_wrap_leds", 32'(u4_leds), 32'd1);
        check("chase_wrap", 32'(u4_wrap), 32'd1);
        cycle();
        check("chase_wrap_once", 32'(u4_wrap), 32'd0);

        // chase down
        dir = 1'b1;
        for (int i = 0; i < 20; i++) cycle();

        // bounce over several full sweeps
        mode = 2'd1;
        for (int i = 0; i < 60; i++) cycle();

        // fill up and down
        mode = 2'd2;
        dir  = 1'b0;
        for (int i = 0; i < 40; i++) cycle();
        dir = 1'b1;
        for (int i = 0; i < 40; i++) cycle();

        // pause mid-step, then resume
        mode = 2'd0;
        dir  = 1'b0;
        cycle();
        cycle();
        en = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        en = 1'b1;
        for (int i = 0; i < 12; i++) cycle();

        // hold mode and mid-step mode/dir changes
        cycle();
        mode = 2'd3;
        for (int i = 0; i < 16; i++) cycle();
        mode = 2'd1;
        for (int i = 0; i < 9; i++) cycle();

        // async reset in bounce, then resume bounce upward
        async_reset();
        for (int i = 0; i < 16; i++) cycle();

        // random soak
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(9, 0) != 0);
            if ($urandom_range(39, 0) == 0) mode = 2'($urandom_range(3, 0));
            if ($urandom_range(29, 0) == 0) dir = 1'($urandom_range(1, 0));
            if ($urandom_range(499, 0) == 0) async_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
